// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and constants for the HUB75 matrix controller
// Purpose: common pixel word type and default word width used by the SPI front
//   end, pixel-write and framebuffer blocks.
// Ports: none (package).
package hub75_pkg;

  localparam int WORD_WIDTH_DEFAULT = 16;

  typedef logic [15:0] pixel_word_t;

endpackage

// File: rtl/hub75_spi_slave_if.sv
// rtl/hub75_spi_slave_if.sv - serial-in / word-out bundle of the SPI deserializer
// Purpose: groups the serial input and the assembled-word outputs.
// Signals:
//   spi_mosi  - serial data, driven by the master while spi_clk is low
//   data      - last completed word
//   pixel_clk - one-cycle word-complete strobe
// Modports: master (SPI source / word consumer), slave (deserializer).
interface hub75_spi_slave_if #(
  parameter int WORD_WIDTH = 16
);

  logic                  spi_mosi;
  logic [WORD_WIDTH-1:0] data;
  logic                  pixel_clk;

  modport master (
    output spi_mosi,
    input  data,
    input  pixel_clk
  );

  modport slave (
    input  spi_mosi,
    output data,
    output pixel_clk
  );

endinterface

// File: rtl/hub75_spi_slave.sv
// rtl/hub75_spi_slave.sv - receive-only SPI (mode 0, MSB first) word deserializer
// Purpose: shifts MOSI in on rising spi_clk, publishes each completed word on
//   data and pulses pixel_clk for one spi_clk period on the final bit's edge.
// Ports:
//   spi_clk - SPI clock, the only clock
//   reset   - synchronous active-low reset
//   bus     - slave modport: spi_mosi in, data / pixel_clk out (registered)
module hub75_spi_slave
  import hub75_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic              spi_clk,
  input  logic              reset,
  hub75_spi_slave_if.slave  bus
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_count_q, bit_count_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  pixel_clk_q, pixel_clk_d;

  always_comb begin
    shift_d     = shift_q;
    bit_count_d = bit_count_q;
    data_d      = data_q;
    pixel_clk_d = 1'b0;
    if (bit_count_q == LAST_BIT) begin
      // Final bit: publish the word straight from the shifter plus the live
      // bit so data and the strobe land on the same edge. shift_q is left as
      // is; the next word overwrites it completely before it is used.
      data_d      = {shift_q, bus.spi_mosi};
      pixel_clk_d = 1'b1;
      bit_count_d = '0;
    end else begin
      shift_d     = {shift_q[WORD_WIDTH-3:0], bus.spi_mosi};
      bit_count_d = bit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge spi_clk) begin
    if (!reset) begin
      shift_q     <= '0;
      bit_count_q <= '0;
      data_q      <= '0;
      pixel_clk_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_count_q <= bit_count_d;
      data_q      <= data_d;
      pixel_clk_q <= pixel_clk_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.pixel_clk = pixel_clk_q;

endmodule

// File: tb/tb_hub75_spi_slave.sv
// tb/tb_hub75_spi_slave.sv - directed self-checking bench for hub75_spi_slave
module tb_hub75_spi_slave;

  logic spi_clk = 1'b0;
  logic reset   = 1'b0;

  int checks   = 0;
  int failures = 0;

  hub75_spi_slave_if #(.WORD_WIDTH(16)) bus ();

  hub75_spi_slave #(.WORD_WIDTH(16)) dut (
    .spi_clk (spi_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send the first n bits of w MSB first; on every edge check the strobe and
  // that data still holds prev, except the 16th bit which must publish w.
  task automatic send_bits(input string tag, input logic [15:0] w, input int n,
                           input logic [15:0] prev);
    for (int i = 0; i < n; i++) begin
      @(negedge spi_clk);
      bus.spi_mosi = w[15-i];
      @(posedge spi_clk);
      #1;
      if (i == 15) begin
        check({tag, "_strobe"}, {15'd0, bus.pixel_clk}, 16'd1);
        check({tag, "_data"}, bus.data, w);
      end else begin
        check({tag, "_nostrobe"}, {15'd0, bus.pixel_clk}, 16'd0);
        check({tag, "_hold"}, bus.data, prev);
      end
    end
  endtask

  // One reset edge with mosi = b; reset is released right after the edge so
  // no extra clock edge is consumed before the next bit.
  task automatic reset_edge(input string tag, input logic b);
    @(negedge spi_clk);
    bus.spi_mosi = b;
    reset = 1'b0;
    @(posedge spi_clk);
    #1;
    check({tag, "_rst_strobe"}, {15'd0, bus.pixel_clk}, 16'd0);
    check({tag, "_rst_data"}, bus.data, 16'h0000);
    reset = 1'b1;
  endtask

  initial begin
    bus.spi_mosi = 1'b0;
    @(posedge spi_clk);
    #1;
    check("reset_data", bus.data, 16'h0000);
    check("reset_strobe", {15'd0, bus.pixel_clk}, 16'd0);
    reset = 1'b1;

    send_bits("b2b_1", 16'hFFF0, 16, 16'h0000);
    send_bits("b2b_2", 16'hFFF0, 16, 16'hFFF0);

    send_bits("order_8001", 16'h8001, 16, 16'hFFF0);
    send_bits("order_1234", 16'h1234, 16, 16'h8001);

    send_bits("midword_a5a5", 16'hA5A5, 7, 16'h1234);
    reset_edge("midword", 1'b0);
    send_bits("midword_5a5a", 16'h5A5A, 16, 16'h0000);

    send_bits("final_beef", 16'hBEEF, 15, 16'h5A5A);
    reset_edge("final", 1'b1);
    send_bits("realign_1357", 16'h1357, 16, 16'h0000);

    send_bits("hold_c3c3", 16'hC3C3, 16, 16'h1357);
    send_bits("hold_0f0f", 16'h0F0F, 16, 16'hC3C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
